// File: rtl/piso_stream.sv
// piso_stream: parallel-in/serial-out converter with valid/ready on both sides
module piso_stream #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] par_data,
  input  logic             par_valid,
  output logic             par_ready,
  output logic             ser_data,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_last,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic s_fire, p_fire;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      shreg <= shreg_nxt;
      cnt   <= cnt_nxt;
    end
  always_comb begin
    ser_valid = state == SHIFT;
    busy      = ser_valid;
    ser_data  = ser_valid & (LSB_FIRST ? shreg[0] : shreg[WIDTH-1]);
    ser_last  = ser_valid & (cnt == CW'(WIDTH - 1));
    s_fire    = ser_valid & ser_ready;
    par_ready = (state == IDLE) | (s_fire & ser_last);
    p_fire    = par_valid & par_ready;
    state_nxt = state;
    shreg_nxt = shreg;
    cnt_nxt   = cnt;
    if (p_fire) begin
      state_nxt = SHIFT;
      shreg_nxt = par_data;
      cnt_nxt   = '0;
    end else if (s_fire & ~ser_last) begin
      shreg_nxt = LSB_FIRST ? shreg >> 1 : shreg << 1;
      cnt_nxt   = cnt + 1'b1;
    end else if (s_fire) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end
  end
endmodule

// File: tb/tb_piso_stream.sv
// tb_piso_stream: random and directed scoreboard bench over three piso_stream configurations
module tb_piso_stream;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0][7:0] pd = '0;
  logic [2:0] pv = '0, sr = '0;
  logic [2:0] pr, sd, sv, sl, bz;
  int checks = 0, failures = 0;
  logic [1:0] exp_q [3][$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : gd
    localparam int W = (g == 2) ? 2 : 8;
    piso_stream #(.WIDTH(W), .LSB_FIRST(g == 1)) dut (
      .clk(clk), .rst_n(rst_n), .par_data(pd[g][W-1:0]), .par_valid(pv[g]),
      .par_ready(pr[g]), .ser_data(sd[g]), .ser_valid(sv[g]), .ser_ready(sr[g]),
      .ser_last(sl[g]), .busy(bz[g])
    );
  end

  function automatic void check(input string name, input int i, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d t=%0t got=%b expected=%b", name, i, $time, act, exp);
    end
  endfunction

  // Model: a word expands into its bit sequence in transmit order; the DUT must
  // be presenting the queue head whenever the queue is non-empty.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        exp_q[i].delete();
        check("rst_valid", i, sv[i], 1'b0);
        check("rst_data", i, sd[i], 1'b0);
        check("rst_last", i, sl[i], 1'b0);
        check("rst_busy", i, bz[i], 1'b0);
        check("rst_ready", i, pr[i], 1'b1);
      end else begin
        int n, w;
        logic [7:0] word;
        n = exp_q[i].size();
        w = (i == 2) ? 2 : 8;
        check("ser_valid", i, sv[i], n != 0);
        check("busy", i, bz[i], n != 0);
        check("par_ready", i, pr[i], (n == 0) || (n == 1 && sr[i]));
        check("ser_data", i, sd[i], n != 0 ? exp_q[i][0][0] : 1'b0);
        check("ser_last", i, sl[i], n != 0 ? exp_q[i][0][1] : 1'b0);
        if (sv[i] && sr[i] && n != 0) void'(exp_q[i].pop_front());
        if (pv[i] && pr[i]) begin
          word = pd[i];
          for (int b = 0; b < w; b++)
            exp_q[i].push_back({b == w - 1, word[(i == 1) ? b : w - 1 - b]});
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int i, input logic [7:0] w);
    bit ok = 0;
    pv[i] = 1'b1;
    pd[i] = w;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      ok = pr[i];
      @(posedge clk);
      #1;
    end
    pv[i] = 1'b0;
    if (!ok) begin
      $display("FAIL send_timeout inst=%0d got=no_accept expected=accept", i);
      $fatal(1);
    end
  endtask

  initial begin
    logic [2:0] acc;
    cyc(3);
    rst_n = 1'b1;
    sr = 3'b111;
    cyc(2);
    send(0, 8'hA5); cyc(9);
    send(1, 8'hA5); cyc(9);
    send(2, 8'h02); cyc(3);
    send(0, 8'h3C); send(0, 8'hFF); cyc(10);
    send(0, 8'h81); cyc(1);
    sr[0] = 1'b0; cyc(3);
    sr[0] = 1'b1; cyc(8);
    sr = 3'b000;
    send(2, 8'h01); cyc(3);
    sr = 3'b111; cyc(3);
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      acc = pv & pr;
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
        if (!pv[i] || acc[i]) begin
          pv[i] = $urandom_range(0, 3) != 0;
          pd[i] = 8'($urandom);
        end
        sr[i] = $urandom_range(0, 3) != 0;
      end
    end
    pv = '0;
    sr = 3'b111;
    for (int k = 0; k < 50 && (exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0; k++) cyc(1);
    if ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0) begin
      $display("FAIL drain_timeout got=pending expected=empty");
      $fatal(1);
    end
    send(0, 8'hF0); send(1, 8'h0F); send(2, 8'h03);
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(12);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
